// File: rtl/row_packer_wr.sv
// Output-side row writer: packs 8-bit result pixels into 64-bit words and writes them
// to BRAM port A, one word-aligned, zero-padded group of words per row.
module row_packer_wr #(
  parameter int ADDR_W    = 8,
  parameter int ROW_PIX   = 30,
  parameter int NUM_ROWS  = 30,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [63:0]       dina,
  output logic              one_row_complete,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [2:0]          byte_cnt_r;
  logic [7:0]          col_cnt_r;
  logic [7:0]          row_cnt_r;
  logic [63:0]         buf_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic                ena_r;
  logic [ADDR_W-1:0]   addra_r;
  logic [63:0]         dina_r;
  logic                orc_r;
  logic                done_r;

  logic                accept_s;
  logic                last_col_s;
  logic                last_row_s;
  logic                trigger_s;
  logic                restart_s;
  logic [63:0]         word_s;

  // Accept/trigger decode and the word as it looks with the incoming byte merged in
  always_comb begin
    accept_s   = pix_valid & (state_r == PACK);
    last_col_s = (col_cnt_r == 8'(ROW_PIX - 1));
    last_row_s = (row_cnt_r == 8'(NUM_ROWS - 1));
    trigger_s  = accept_s & ((byte_cnt_r == 3'd7) | last_col_s);
    restart_s  = start & (state_r != PACK);
    word_s     = buf_r;
    word_s[{byte_cnt_r, 3'b000} +: 8] = pix_data;
  end

  // Next-state logic; start is only honoured outside PACK
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = PACK;
        else       state_nx_s = IDLE;
      end
      PACK: begin
        if (trigger_s & last_col_s & last_row_s) state_nx_s = DONE;
        else                                     state_nx_s = PACK;
      end
      DONE: begin
        if (start) state_nx_s = PACK;
        else       state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, counters, shift buffer and registered BRAM strobes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      byte_cnt_r <= 3'd0;
      col_cnt_r  <= 8'd0;
      row_cnt_r  <= 8'd0;
      buf_r      <= 64'd0;
      waddr_r    <= ADDR_W'(BASE_ADDR);
      ena_r      <= 1'b0;
      addra_r    <= ADDR_W'(BASE_ADDR);
      dina_r     <= 64'd0;
      orc_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ena_r   <= trigger_s;
      orc_r   <= trigger_s & last_col_s;
      done_r  <= (state_r == DONE) & ~start;
      if (restart_s) begin
        byte_cnt_r <= 3'd0;
        col_cnt_r  <= 8'd0;
        row_cnt_r  <= 8'd0;
        buf_r      <= 64'd0;
        waddr_r    <= ADDR_W'(BASE_ADDR);
      end else if (accept_s) begin
        // A row-end byte closes the word early; the untouched upper lanes are still zero
        if (trigger_s) begin
          dina_r     <= word_s;
          addra_r    <= waddr_r;
          waddr_r    <= waddr_r + ADDR_W'(1);
          byte_cnt_r <= 3'd0;
          buf_r      <= 64'd0;
        end else begin
          buf_r      <= word_s;
          byte_cnt_r <= byte_cnt_r + 3'd1;
        end
        if (last_col_s) begin
          col_cnt_r <= 8'd0;
          row_cnt_r <= row_cnt_r + 8'd1;
        end else begin
          col_cnt_r <= col_cnt_r + 8'd1;
        end
      end
    end
  end

  assign pix_ready        = (state_r == PACK);
  assign ena              = ena_r;
  assign wea              = ena_r;
  assign addra            = addra_r;
  assign dina             = dina_r;
  assign one_row_complete = orc_r;
  assign done             = done_r;

endmodule

// File: tb/tb_row_packer_wr.sv
// Randomized bench for row_packer_wr: default geometry (30x30) and a 16x2 frame,
// with every BRAM write checked against a pixel-stream reference model.
module tb_row_packer_wr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  start, pix_valid, pix_ready, ena, wea, orc, done;
  logic [7:0]  pix_data [2];
  logic [7:0]  addra [2];
  logic [63:0] dina [2];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          d;
    logic [7:0]  a;
    logic [63:0] w;
    logic        o;
  } wr_t;

  byte unsigned px_q[$];
  wr_t got_q[$];
  wr_t exp_q[$];

  row_packer_wr u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .pix_data(pix_data[0]),
    .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]), .ena(ena[0]), .wea(wea[0]),
    .addra(addra[0]), .dina(dina[0]), .one_row_complete(orc[0]), .done(done[0])
  );

  row_packer_wr #(.ROW_PIX(16), .NUM_ROWS(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .pix_data(pix_data[1]),
    .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]), .ena(ena[1]), .wea(wea[1]),
    .addra(addra[1]), .dina(dina[1]), .one_row_complete(orc[1]), .done(done[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: logs every BRAM write and checks the strobe relationships
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ena[d] | wea[d] | orc[d]) begin
        check("wea_eq_ena", 64'(wea[d]), 64'(ena[d]));
        check("orc_needs_ena", 64'(orc[d] & ~ena[d]), 64'd0);
        if (ena[d]) got_q.push_back('{d, addra[d], dina[d], orc[d]});
      end
    end
  end

  // Reference: pixel i sits at row i/rp, column i%rp; a word is written when its last pixel arrives
  task automatic model(input int d, input int rp);
    int rw = (rp + 7) / 8;
    logic [63:0] w = 64'd0;
    exp_q.delete();
    for (int i = 0; i < px_q.size(); i++) begin
      int row  = i / rp;
      int col  = i % rp;
      int lane = col % 8;
      w = w | (64'(px_q[i]) << (8 * lane));
      if (lane == 7 || col == rp - 1) begin
        exp_q.push_back('{d, 8'(row * rw + col / 8), w, (col == rp - 1)});
        w = 64'd0;
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_dut"},  64'(got_q[i].d), 64'(exp_q[i].d));
      check({tag, "_addr"}, 64'(got_q[i].a), 64'(exp_q[i].a));
      check({tag, "_data"}, got_q[i].w, exp_q[i].w);
      check({tag, "_orc"},  64'(got_q[i].o), 64'(exp_q[i].o));
    end
    got_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    got_q.delete();
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Drives px_q[lo..hi-1]; returns on the negedge of the cycle after the last accept
  task automatic send(input int d, input int lo, input int hi, input bit throttle);
    int idx = lo;
    int budget = 0;
    while (idx < hi && budget < 20000) begin
      @(negedge clk);
      budget++;
      if (throttle && $urandom_range(0, 1) == 0) begin
        pix_valid[d] = 1'b0;
      end else begin
        pix_valid[d] = 1'b1;
        pix_data[d]  = px_q[idx];
        if (pix_ready[d]) idx++;
      end
    end
    @(negedge clk);
    pix_valid[d] = 1'b0;
    if (idx < hi) check("send_timeout", 64'(idx), 64'(hi));
  endtask

  initial begin
    reset_n = 1'b0; start = 2'b00; pix_valid = 2'b00;
    pix_data[0] = 8'h00; pix_data[1] = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset: valid without start must not be accepted
    pix_valid = 2'b11;
    repeat (3) @(negedge clk);
    check("idle_ready", 64'(pix_ready), 64'd0);
    check("idle_ena",   64'(ena), 64'd0);
    check("idle_done",  64'(done), 64'd0);
    check("idle_addra", 64'(addra[0]), 64'd0);
    check("idle_dina",  dina[0], 64'd0);
    check("idle_writes", 64'(got_q.size()), 64'd0);
    pix_valid = 2'b00;

    // One full word, strobe one cycle after the 8th accept
    px_q.delete();
    for (int i = 1; i <= 8; i++) px_q.push_back(8'(i));
    pulse_start(0);
    send(0, 0, 8, 1'b0);
    check("word_ena",   64'(ena[0]), 64'd1);
    check("word_addra", 64'(addra[0]), 64'd0);
    check("word_dina",  dina[0], 64'h0807060504030201);
    repeat (2) @(negedge clk);
    model(0, 30);
    compare_writes("full_word");

    // Row end with zero padding
    do_reset();
    px_q.delete();
    for (int i = 0; i < 30; i++) px_q.push_back(8'(i));
    pulse_start(0);
    send(0, 0, 30, 1'b0);
    repeat (3) @(negedge clk);
    check("row_end_w3", (got_q.size() > 3) ? got_q[3].w : 64'd0, 64'h00001D1C1B1A1918);
    model(0, 30);
    compare_writes("row_end");

    // Throttled full frame: first row matches the back-to-back row, rest random
    do_reset();
    px_q.delete();
    for (int i = 0; i < 30; i++) px_q.push_back(8'(i));
    for (int i = 30; i < 900; i++) px_q.push_back(8'($urandom));
    pulse_start(0);
    send(0, 0, 900, 1'b1);
    repeat (3) @(negedge clk);
    check("frame_done",  64'(done[0]), 64'd1);
    check("frame_ready", 64'(pix_ready[0]), 64'd0);
    model(0, 30);
    compare_writes("throttled");

    // 16x2 frame completion, then restart
    px_q.delete();
    for (int i = 0; i < 32; i++) px_q.push_back(8'($urandom));
    pulse_start(1);
    send(1, 0, 32, 1'b0);
    check("fin_ena",   64'(ena[1]), 64'd1);
    check("fin_addra", 64'(addra[1]), 64'd3);
    check("fin_orc",   64'(orc[1]), 64'd1);
    check("fin_done_early", 64'(done[1]), 64'd0);
    check("fin_ready", 64'(pix_ready[1]), 64'd0);
    @(negedge clk);
    check("fin_done",   64'(done[1]), 64'd1);
    check("fin_ready2", 64'(pix_ready[1]), 64'd0);
    pix_valid[1] = 1'b1;
    repeat (5) @(negedge clk);
    pix_valid[1] = 1'b0;
    check("fin_done_held", 64'(done[1]), 64'd1);
    model(1, 16);
    compare_writes("frame_b");
    px_q.delete();
    for (int i = 0; i < 16; i++) px_q.push_back(8'($urandom));
    pulse_start(1);
    check("restart_done",  64'(done[1]), 64'd0);
    check("restart_ready", 64'(pix_ready[1]), 64'd1);
    send(1, 0, 16, 1'b1);
    repeat (3) @(negedge clk);
    model(1, 16);
    compare_writes("restart_b");

    // Mid-frame reset drops the partial word
    do_reset();
    px_q.delete();
    for (int i = 0; i < 5; i++) px_q.push_back(8'($urandom));
    pulse_start(0);
    send(0, 0, 5, 1'b0);
    do_reset();
    check("midrst_ready", 64'(pix_ready[0]), 64'd0);
    px_q.delete();
    for (int i = 0; i < 8; i++) px_q.push_back(8'($urandom));
    pulse_start(0);
    send(0, 0, 8, 1'b0);
    repeat (3) @(negedge clk);
    model(0, 30);
    compare_writes("mid_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
